// File: rtl/axi_pkg.sv
// Shared AXI encodings, width constants and the single-beat master FSM state type.
package axi_pkg;

  localparam int unsigned AxiLenW   = 4;
  localparam int unsigned AxiSizeW  = 3;
  localparam int unsigned AxiBurstW = 2;
  localparam int unsigned AxiRespW  = 2;

  localparam logic [AxiBurstW-1:0] AxiBurstFixed = 2'd0;
  localparam logic [AxiBurstW-1:0] AxiBurstIncr  = 2'd1;

  localparam logic [AxiRespW-1:0] AxiRespOkay   = 2'd0;
  localparam logic [AxiRespW-1:0] AxiRespExOkay = 2'd1;
  localparam logic [AxiRespW-1:0] AxiRespSlvErr = 2'd2;
  localparam logic [AxiRespW-1:0] AxiRespDecErr = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddrData,
    StWrResp,
    StErrRsp
  } mst_state_e;

  // True when the size is supported (1, 2 or 4 bytes) and the address is naturally aligned.
  function automatic logic req_aligned(input logic [1:0] addr_lsb, input logic [2:0] size);
    case (size)
      3'd0:    return 1'b1;
      3'd1:    return ~addr_lsb[0];
      3'd2:    return addr_lsb == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_single_beat_master.sv
// One-outstanding request port to single-beat AXI read/write master with a registered
// one-cycle response pulse; misaligned requests are answered locally with an error.
module axi_single_beat_master
  import axi_pkg::*;
#(
  parameter int unsigned     ID_W      = 4,
  parameter int unsigned     ADDR_W    = 32,
  parameter int unsigned     DATA_W    = 32,
  parameter logic [ID_W-1:0] MASTER_ID = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [ID_W-1:0]       AWID,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [AxiLenW-1:0]    AWLEN,
  output logic [AxiSizeW-1:0]   AWSIZE,
  output logic [AxiBurstW-1:0]  AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [ID_W-1:0]       BID,
  input  logic [AxiRespW-1:0]   BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ID_W-1:0]       ARID,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic [AxiLenW-1:0]    ARLEN,
  output logic [AxiSizeW-1:0]   ARSIZE,
  output logic [AxiBurstW-1:0]  ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [ID_W-1:0]       RID,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [AxiRespW-1:0]   RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  mst_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rd_err_q, rd_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rd_err_q    <= rd_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rd_err_d    = rd_err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rd_err_d  = 1'b0;
          if (!req_aligned(req_addr[1:0], req_size)) begin
            state_d = StErrRsp;
          end else begin
            state_d = req_write ? StWrAddrData : StRdAddr;
          end
        end
      end
      StRdAddr: begin
        if (ARREADY) state_d = StRdData;
      end
      StRdData: begin
        if (RVALID) begin
          // Error is sticky so that any premature non-last beat poisons the response.
          rd_err_d = rd_err_q | (RRESP != AxiRespOkay) | (RID != MASTER_ID) | ~RLAST;
          if (RLAST) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b1;
            rsp_err_d   = rd_err_d;
            rsp_rdata_d = rd_err_d ? '0 : RDATA;
          end
        end
      end
      StWrAddrData: begin
        aw_done_d = aw_done_q | AWREADY;
        w_done_d  = w_done_q | WREADY;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (BVALID) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (BRESP != AxiRespOkay) | (BID != MASTER_ID);
        end
      end
      StErrRsp: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = '0;
  assign AWSIZE  = size_q;
  assign AWBURST = AxiBurstIncr;
  assign AWVALID = (state_q == StWrAddrData) && !aw_done_q;

  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;
  assign WLAST  = 1'b1;
  assign WVALID = (state_q == StWrAddrData) && !w_done_q;

  assign BREADY = (state_q == StWrResp);

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = '0;
  assign ARSIZE  = size_q;
  assign ARBURST = AxiBurstIncr;
  assign ARVALID = (state_q == StRdAddr);

  assign RREADY = (state_q == StRdData);

endmodule

// File: tb/tb_axi_single_beat_master.sv
// Randomized bench: per-transaction slave behaviour plus an arithmetic latency/result model.
module tb_axi_single_beat_master;

  localparam logic [3:0] MID = 4'h3;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int total = 0;
  int bad   = 0;

  axi_single_beat_master #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .MASTER_ID(MID)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
    BVALID = 1'b0; BID = '0; BRESP = '0;
    RVALID = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
  endtask

  // Caller is positioned 1 time unit after a rising edge; that cycle is the acceptance cycle.
  task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] sdata,
                         input logic [1:0] sresp, input bit bad_id, input int ard,
                         input int awd, input int wd, input int rd, input int bd,
                         input int extra);
    bit loc_err, exp_err, r_on, b_on, b_started, last_now, rsp_err_s, ready_at_rsp;
    int exp_lat, ar_cnt, aw_cnt, w_cnt, b_cnt, arv, awv, wv, rsp_cnt, rsp_cyc, pay_bad;
    int beats, r_wait, b_wait;
    logic [31:0] exp_rdata, rsp_rdata_s;
    logic [3:0]  sid;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; arv = 0; awv = 0; wv = 0;
    rsp_cnt = 0; rsp_cyc = -1; pay_bad = 0; beats = 0; r_wait = 0; b_wait = 0;
    r_on = 0; b_on = 0; b_started = 0; rsp_err_s = 0; rsp_rdata_s = '0; ready_at_rsp = 0;
    sid = bad_id ? (MID ^ 4'h1) : MID;

    loc_err = (size > 3'd2) || ((addr % (32'd1 << size)) != 32'd0);
    if (loc_err) begin
      exp_err = 1'b1; exp_rdata = '0; exp_lat = 2;
    end else if (!wr) begin
      exp_err   = (sresp != 2'b00) || bad_id || (extra > 0);
      exp_rdata = exp_err ? 32'd0 : sdata;
      exp_lat   = ard + rd + extra + 3;
    end else begin
      exp_err   = (sresp != 2'b00) || bad_id;
      exp_rdata = '0;
      exp_lat   = ((awd > wd) ? awd : wd) + bd + 3;
    end

    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_wdata = wdata; req_wstrb = wstrb;

    for (int c = 1; c <= 80; c++) begin
      @(posedge ACLK); #1;
      req_valid = 1'b0;
      slave_idle();
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc = c; rsp_err_s = rsp_err; rsp_rdata_s = rsp_rdata; ready_at_rsp = req_ready;
        end
      end
      if (r_on) begin
        if (r_wait >= rd) begin
          last_now = (beats == extra);
          RVALID = 1'b1; RID = sid; RRESP = sresp; RLAST = last_now;
          RDATA = last_now ? sdata : $urandom;
          if (RREADY) begin
            beats++;
            if (last_now) r_on = 0;
          end
        end else r_wait++;
      end
      if (b_on) begin
        if (b_wait >= bd) begin
          BVALID = 1'b1; BID = sid; BRESP = sresp;
          if (BREADY) begin b_cnt++; b_on = 0; end
        end else b_wait++;
      end
      if (ARVALID) begin
        arv++;
        if (ARADDR !== addr || ARSIZE !== size || ARLEN !== 4'd0 || ARBURST !== 2'b01 ||
            ARID !== MID) pay_bad++;
        if (arv > ard) begin ARREADY = 1'b1; ar_cnt++; r_on = 1; r_wait = 0; end
      end
      if (AWVALID) begin
        awv++;
        if (AWADDR !== addr || AWSIZE !== size || AWLEN !== 4'd0 || AWBURST !== 2'b01 ||
            AWID !== MID) pay_bad++;
        if (awv > awd) begin AWREADY = 1'b1; aw_cnt++; end
      end
      if (WVALID) begin
        wv++;
        if (WDATA !== wdata || WSTRB !== wstrb || WLAST !== 1'b1) pay_bad++;
        if (wv > wd) begin WREADY = 1'b1; w_cnt++; end
      end
      if (aw_cnt > 0 && w_cnt > 0 && !b_started) begin b_started = 1; b_on = 1; b_wait = 0; end
      if (rsp_cyc >= 0 && c >= rsp_cyc + 2) break;
    end
    slave_idle();

    check_eq({tag, "_lat"}, 64'(rsp_cyc), 64'(exp_lat));
    check_eq({tag, "_rsp_cnt"}, 64'(rsp_cnt), 64'd1);
    check_eq({tag, "_err"}, 64'(rsp_err_s), 64'(exp_err));
    check_eq({tag, "_rdata"}, 64'(rsp_rdata_s), 64'(exp_rdata));
    check_eq({tag, "_ready_at_rsp"}, 64'(ready_at_rsp), 64'd1);
    check_eq({tag, "_payload_bad"}, 64'(pay_bad), 64'd0);
    check_eq({tag, "_ar_cycles"}, 64'(arv), (loc_err || wr) ? 64'd0 : 64'(ard + 1));
    check_eq({tag, "_aw_cycles"}, 64'(awv), (loc_err || !wr) ? 64'd0 : 64'(awd + 1));
    check_eq({tag, "_w_cycles"}, 64'(wv), (loc_err || !wr) ? 64'd0 : 64'(wd + 1));
    check_eq({tag, "_b_cnt"}, 64'(b_cnt), (loc_err || !wr) ? 64'd0 : 64'd1);
    check_eq({tag, "_r_beats"}, 64'(beats), (loc_err || wr) ? 64'd0 : 64'(extra + 1));
  endtask

  int arv_seen, rsp_seen;

  initial begin
    ARESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0;
    slave_idle();
    repeat (2) @(posedge ACLK);
    #1;
    check_eq("rst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 64'd0);
    check_eq("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_addr", 64'({ARADDR, AWADDR}), 64'd0);
    check_eq("rst_wdata", 64'(WDATA), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    run_txn("t1_rd", 1'b0, 32'h0001_0004, 3'd2, '0, '0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    run_txn("t2_wr", 1'b1, 32'h0001_0002, 3'd1, 32'h1234_0000, 4'b1100, '0, 2'b00, 0,
            0, 3, 0, 0, 0, 0);
    run_txn("t3_wr_slverr", 1'b1, 32'h0000_0100, 3'd2, 32'hCAFE_F00D, 4'hF, '0, 2'b10, 0,
            0, 0, 0, 0, 0, 0);
    run_txn("t4_misal", 1'b0, 32'h0001_0001, 3'd2, '0, '0, 32'h5555_AAAA, 2'b00, 0,
            0, 0, 0, 0, 0, 0);
    run_txn("t5_two_beats", 1'b0, 32'h0000_0040, 3'd2, '0, '0, 32'h0BAD_CAFE, 2'b00, 0,
            0, 0, 0, 0, 0, 1);
    run_txn("t_badsize", 1'b1, 32'h0000_0000, 3'd3, 32'h1, 4'h1, '0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    run_txn("t_badid_rd", 1'b0, 32'h0000_0008, 3'd2, '0, '0, 32'h7777_1111, 2'b00, 1,
            1, 0, 0, 2, 0, 0);

    // Reset while ARVALID is up and ARREADY is held low.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010; req_size = 3'd2;
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    check_eq("t6_arvalid_before", 64'(ARVALID), 64'd1);
    #1 ARESETn = 1'b0;
    #1;
    check_eq("t6_arvalid_in_rst", 64'(ARVALID), 64'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    arv_seen = 0; rsp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge ACLK); #1;
      if (ARVALID) arv_seen++;
      if (rsp_valid) rsp_seen++;
    end
    check_eq("t6_no_ar_after", 64'(arv_seen), 64'd0);
    check_eq("t6_no_rsp_after", 64'(rsp_seen), 64'd0);
    check_eq("t6_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 40; i++) begin
      bit          wr, bid;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [1:0]  rs;
      int          ex;
      wr  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bid = ($urandom_range(0, 7) == 0);
      ex  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      run_txn("rnd", wr, a, sz, $urandom, 4'($urandom), $urandom, rs, bid,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
